// File: rtl/dep_issue_scheduler_if.sv
// ============================================================================
// Module  : dep_issue_scheduler_if
// Brief   : Allocation, completion and issue handshake bundle for the scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface dep_issue_scheduler_if #(
    parameter int BS = 32,
    parameter int IW = $clog2(BS)
);
    logic            alloc_valid;
    logic [IW-1:0]   alloc_index;
    logic [0:BS-1]   alloc_dept;
    logic            complete_valid;
    logic [IW-1:0]   complete_index;
    logic            issue_ready;
    logic            issue_valid;
    logic [IW-1:0]   issue_index;
    logic [0:BS-1]   slot_busy;
    logic            full;
    logic            proto_err;

    modport master (
        output alloc_valid, alloc_index, alloc_dept,
        output complete_valid, complete_index,
        output issue_ready,
        input  issue_valid, issue_index, slot_busy, full, proto_err
    );

    modport slave (
        input  alloc_valid, alloc_index, alloc_dept,
        input  complete_valid, complete_index,
        input  issue_ready,
        output issue_valid, issue_index, slot_busy, full, proto_err
    );
endinterface

`default_nettype wire

// File: rtl/dep_issue_scheduler.sv
// ============================================================================
// Module  : dep_issue_scheduler
// Brief   : Per-slot dependency tracker presenting one dependency-free slot
//           at a time over a valid/ready issue handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dep_issue_scheduler #(
    parameter int BS = 32,
    parameter int IW = $clog2(BS)
) (
    input  logic                  clk,
    input  logic                  rst,
    dep_issue_scheduler_if.slave  bus
);

    localparam logic [1:0] c_free = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_pick = 2'd2;
    localparam logic [1:0] c_iss  = 2'd3;

    logic            r_issue_valid;
    logic [IW-1:0]   r_issue_index;
    logic            r_proto_err;

    logic [0:BS-1]   w_busy;
    logic [0:BS-1]   w_iss;
    logic [0:BS-1]   w_ready;
    logic [0:BS-1]   w_cmp_mask;
    logic [0:BS-1]   w_alloc_mask;
    logic [0:BS-1]   w_hs_mask;
    logic [0:BS-1]   w_pick_mask;
    logic [0:BS-1]   w_busy_pc;
    logic [0:BS-1]   w_alloc_row;

    logic            w_cmp_ok;
    logic            w_cmp_err;
    logic            w_alloc_ok;
    logic            w_alloc_err;
    logic            w_hs;
    logic            w_load;
    logic            w_pick;
    logic            w_pick_found;
    logic [IW-1:0]   w_pick_index;

    // Only an issued slot may complete; a PICK slot is still owned by the output register.
    assign w_cmp_ok  = bus.complete_valid && w_iss[bus.complete_index];
    assign w_cmp_err = bus.complete_valid && !w_cmp_ok;

    // Occupancy after completion, so a slot may be freed and reallocated on the same edge.
    assign w_busy_pc   = w_busy & ~w_cmp_mask;
    assign w_alloc_ok  = bus.alloc_valid && !w_busy_pc[bus.alloc_index];
    assign w_alloc_err = bus.alloc_valid && !w_alloc_ok;
    assign w_alloc_row = bus.alloc_dept & w_busy_pc & ~w_alloc_mask;

    assign w_hs   = r_issue_valid && bus.issue_ready;
    assign w_load = !r_issue_valid || w_hs;
    assign w_pick = w_load && w_pick_found;

    // Ready set is taken from registered state: allocations and column clears
    // made on this edge become visible to the picker one edge later.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_index = '0;
        for (int j = BS - 1; j >= 0; j--) begin
            if (w_ready[j]) begin
                w_pick_found = 1'b1;
                w_pick_index = IW'(j);
            end
        end
    end

    for (genvar j = 0; j < BS; j++) begin : g_slot
        logic [1:0]    r_state;
        logic [0:BS-1] r_dep;

        assign w_cmp_mask[j]   = w_cmp_ok   && (bus.complete_index == IW'(j));
        assign w_alloc_mask[j] = w_alloc_ok && (bus.alloc_index    == IW'(j));
        assign w_hs_mask[j]    = w_hs       && (r_issue_index      == IW'(j));
        assign w_pick_mask[j]  = w_pick     && (w_pick_index       == IW'(j));

        assign w_busy[j]  = (r_state != c_free);
        assign w_iss[j]   = (r_state == c_iss);
        assign w_ready[j] = (r_state == c_wait) && (r_dep == '0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= c_free;
                r_dep   <= '0;
            end else begin
                r_dep <= r_dep & ~w_cmp_mask;
                if (w_cmp_mask[j]) begin
                    r_state <= c_free;
                end
                if (w_alloc_mask[j]) begin
                    r_state <= c_wait;
                    r_dep   <= w_alloc_row;
                end
                if (w_hs_mask[j]) begin
                    r_state <= c_iss;
                end
                if (w_pick_mask[j]) begin
                    r_state <= c_pick;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_index <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | w_cmp_err | w_alloc_err;
            if (w_load) begin
                r_issue_valid <= w_pick_found;
                if (w_pick_found) begin
                    r_issue_index <= w_pick_index;
                end
            end
        end
    end

    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_index = r_issue_index;
    assign bus.slot_busy   = w_busy;
    assign bus.full        = &w_busy;
    assign bus.proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_dep_issue_scheduler.sv
// ============================================================================
// Module  : tb_dep_issue_scheduler
// Brief   : Directed and randomized checks of dep_issue_scheduler against a
//           set-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dep_issue_scheduler;
    localparam int BS = 32;
    localparam int IW = $clog2(BS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dep_issue_scheduler_if #(.BS(BS), .IW(IW)) bus ();
    dep_issue_scheduler #(.BS(BS), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: which slots hold an instruction, which have been handed
    // to the consumer, what each waits on, and what the output register shows.
    bit          m_live   [BS];
    bit          m_issued [BS];
    bit [BS-1:0] m_deps   [BS];
    bit          m_pv;
    int          m_pi;
    bit          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_live[i] = 1'b0;
            m_issued[i] = 1'b0;
            m_deps[i] = '0;
        end
        m_pv = 1'b0;
        m_pi = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        int  elig;
        int  c;
        int  a;
        bit  hs;
        elig = -1;
        for (int i = 0; i < BS; i++)
            if (elig < 0 && m_live[i] && !m_issued[i] && !(m_pv && m_pi == i) && m_deps[i] == '0)
                elig = i;
        if (bus.complete_valid) begin
            c = int'(bus.complete_index);
            if (m_live[c] && m_issued[c]) begin
                m_live[c] = 1'b0;
                m_issued[c] = 1'b0;
                for (int i = 0; i < BS; i++) m_deps[i][c] = 1'b0;
            end else m_err = 1'b1;
        end
        if (bus.alloc_valid) begin
            a = int'(bus.alloc_index);
            if (!m_live[a]) begin
                for (int j = 0; j < BS; j++)
                    m_deps[a][j] = bus.alloc_dept[j] && m_live[j] && (j != a);
                m_live[a] = 1'b1;
                m_issued[a] = 1'b0;
            end else m_err = 1'b1;
        end
        hs = m_pv && bus.issue_ready;
        if (hs) m_issued[m_pi] = 1'b1;
        if (!m_pv || hs) begin
            if (elig >= 0) begin
                m_pv = 1'b1;
                m_pi = elig;
            end else m_pv = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [0:BS-1] exp_busy;
        bit            exp_full;
        exp_full = 1'b1;
        for (int j = 0; j < BS; j++) begin
            exp_busy[j] = m_live[j];
            exp_full = exp_full & m_live[j];
        end
        check({tag, "_valid"}, bus.issue_valid, m_pv);
        check({tag, "_index"}, bus.issue_index, m_pi);
        check({tag, "_busy"},  bus.slot_busy,   exp_busy);
        check({tag, "_full"},  bus.full,        exp_full);
        check({tag, "_err"},   bus.proto_err,   m_err);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_index = '0;
        bus.alloc_dept = '0;
        bus.complete_valid = 1'b0;
        bus.complete_index = '0;
    endtask

    task automatic do_alloc(input int a, input logic [0:BS-1] d);
        idle();
        bus.alloc_valid = 1'b1;
        bus.alloc_index = IW'(a);
        bus.alloc_dept = d;
    endtask

    task automatic do_complete(input int c);
        idle();
        bus.complete_valid = 1'b1;
        bus.complete_index = IW'(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.issue_valid, 0);
        check({tag, "_index"}, bus.issue_index, 0);
        check({tag, "_busy"},  bus.slot_busy,   0);
        check({tag, "_full"},  bus.full,        0);
        check({tag, "_err"},   bus.proto_err,   0);
    endtask

    logic [0:BS-1] d;
    int            fq[$];
    int            cq[$];
    int            csel;

    initial begin
        idle();
        bus.issue_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single ready slot: busy after the alloc edge, presented one edge later.
        do_alloc(3, '0);
        cycle("t1_alloc");
        check("t1_busy3", bus.slot_busy[3], 1);
        check("t1_notyet", bus.issue_valid, 0);
        idle();
        cycle("t1_pick");
        check("t1_valid", bus.issue_valid, 1);
        check("t1_index", bus.issue_index, 3);
        bus.issue_ready = 1'b1;
        cycle("t1_hs");
        check("t1_drained", bus.issue_valid, 0);
        bus.issue_ready = 1'b0;
        do_complete(3);
        cycle("t1_cmp");

        // Dependant becomes visible one edge after its producer completes.
        do_alloc(0, '0);
        cycle("t2_a0");
        d = '0;
        d[0] = 1'b1;
        do_alloc(1, d);
        cycle("t2_a1");
        check("t2_idx0", bus.issue_index, 0);
        idle();
        bus.issue_ready = 1'b1;
        cycle("t2_hs0");
        check("t2_blocked", bus.issue_valid, 0);
        bus.issue_ready = 1'b0;
        do_complete(0);
        cycle("t2_cmp0");
        check("t2_not_same_edge", bus.issue_valid, 0);
        idle();
        cycle("t2_pick1");
        check("t2_valid1", bus.issue_valid, 1);
        check("t2_idx1", bus.issue_index, 1);
        bus.issue_ready = 1'b1;
        cycle("t2_hs1");
        bus.issue_ready = 1'b0;
        do_complete(1);
        cycle("t2_cmp1");

        // Slots 5, 2, 9 released together by one producer, issued lowest first.
        do_alloc(10, '0);
        cycle("t3_a10");
        idle();
        cycle("t3_p10");
        bus.issue_ready = 1'b1;
        cycle("t3_hs10");
        bus.issue_ready = 1'b0;
        d = '0;
        d[10] = 1'b1;
        do_alloc(5, d);
        cycle("t3_a5");
        do_alloc(2, d);
        cycle("t3_a2");
        do_alloc(9, d);
        cycle("t3_a9");
        do_complete(10);
        bus.issue_ready = 1'b1;
        cycle("t3_cmp10");
        idle();
        cycle("t3_s0");
        check("t3_seq0", bus.issue_index, 2);
        cycle("t3_s1");
        check("t3_seq1", bus.issue_index, 5);
        cycle("t3_s2");
        check("t3_seq2", bus.issue_index, 9);
        check("t3_seq2v", bus.issue_valid, 1);
        cycle("t3_s3");
        check("t3_done", bus.issue_valid, 0);
        bus.issue_ready = 1'b0;

        // Stall: presented slot 7 holds while other slots complete.
        do_alloc(7, '0);
        cycle("t4_a7");
        idle();
        cycle("t4_p7");
        for (int k = 0; k < 4; k++) begin
            if (k == 0) do_complete(2);
            else if (k == 1) do_complete(5);
            else if (k == 2) do_complete(9);
            else idle();
            cycle("t4_stall");
            check("t4_hold_v", bus.issue_valid, 1);
            check("t4_hold_i", bus.issue_index, 7);
        end
        idle();
        bus.issue_ready = 1'b1;
        cycle("t4_hs7");
        bus.issue_ready = 1'b0;
        do_complete(7);
        cycle("t4_cmp7");

        // Complete and reallocate the same slot on one edge; self-dependency dropped.
        do_alloc(4, '0);
        cycle("t5_a4");
        idle();
        cycle("t5_p4");
        bus.issue_ready = 1'b1;
        cycle("t5_hs4");
        bus.issue_ready = 1'b0;
        d = '0;
        d[4] = 1'b1;
        do_alloc(4, d);
        bus.complete_valid = 1'b1;
        bus.complete_index = IW'(4);
        cycle("t5_swap");
        check("t5_noerr", bus.proto_err, 0);
        check("t5_busy4", bus.slot_busy[4], 1);
        idle();
        cycle("t5_p4b");
        check("t5_valid", bus.issue_valid, 1);
        check("t5_index", bus.issue_index, 4);
        bus.issue_ready = 1'b1;
        cycle("t5_hs4b");
        bus.issue_ready = 1'b0;
        do_complete(4);
        cycle("t5_cmp4b");

        // Randomized legal traffic against the model.
        for (int n = 0; n < 800; n++) begin
            idle();
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            csel = -1;
            cq.delete();
            for (int i = 0; i < BS; i++) if (m_live[i] && m_issued[i]) cq.push_back(i);
            if (cq.size() > 0 && $urandom_range(0, 1) == 1) begin
                csel = cq[$urandom_range(0, cq.size() - 1)];
                bus.complete_valid = 1'b1;
                bus.complete_index = IW'(csel);
            end
            fq.delete();
            for (int i = 0; i < BS; i++) if (!m_live[i] || i == csel) fq.push_back(i);
            if (fq.size() > 0 && $urandom_range(0, 2) != 0) begin
                bus.alloc_valid = 1'b1;
                bus.alloc_index = IW'(fq[$urandom_range(0, fq.size() - 1)]);
                bus.alloc_dept = $urandom() & $urandom();
            end
            cycle("rnd");
        end

        // Protocol errors, then asynchronous reset in the middle of a cycle.
        idle();
        bus.issue_ready = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_complete(6);
        cycle("t6_cmpfree");
        check("t6_err", bus.proto_err, 1);
        do_alloc(11, '0);
        cycle("t6_a11");
        do_alloc(12, '0);
        cycle("t6_a12");
        do_alloc(12, '0);
        cycle("t6_a12dup");
        check("t6_err_sticky", bus.proto_err, 1);
        check("t6_presented", bus.issue_valid, 1);
        idle();
        bus.issue_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("t6_async");
        @(posedge clk);
        #1;
        check_reset_outputs("t6_held");
        bus.issue_ready = 1'b0;
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
